// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared card-game types: result codes, judge states, card fields
package game_pkg;

    localparam int COLOR_W = 2;
    localparam int NUM_W   = 3;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_P1   = 2'b01,
        RES_P2   = 2'b10,
        RES_DRAW = 2'b11
    } result_t;

    typedef enum logic [2:0] {
        WAIT_P1 = 3'd0,
        WAIT_P2 = 3'd1,
        JUDGE   = 3'd2,
        SHOW    = 3'd3,
        OVER    = 3'd4
    } state_t;

    // Number is the upper field so a plain unsigned compare ranks number first, colour second.
    typedef struct packed {
        logic [NUM_W-1:0]   number;
        logic [COLOR_W-1:0] color;
    } card_t;

    function automatic result_t judge_cards(input card_t a, input card_t b);
        if (a > b) return RES_P1;
        if (b > a) return RES_P2;
        return RES_DRAW;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/strobe_delay.sv
// rtl/strobe_delay.sv - DEPTH-stage shift register aligning {draw_en, whose} with card values
module strobe_delay #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic draw_en,
    input  logic whose,
    output logic d_draw,
    output logic d_whose
);

    logic [DEPTH-1:0] draw_sr;
    logic [DEPTH-1:0] whose_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            draw_sr  <= '0;
            whose_sr <= '0;
        end else begin
            draw_sr[0]  <= draw_en;
            whose_sr[0] <= whose;
            for (int i = 1; i < DEPTH; i++) begin
                draw_sr[i]  <= draw_sr[i-1];
                whose_sr[i] <= whose_sr[i-1];
            end
        end
    end

    assign d_draw  = draw_sr[DEPTH-1];
    assign d_whose = whose_sr[DEPTH-1];

endmodule

// File: rtl/round_judge.sv
// rtl/round_judge.sv - pairs P1/P2 draws, judges each round, keeps score and match state
module round_judge
    import game_pkg::*;
#(
    parameter int VALUE_LAT   = 3,
    parameter int WIN_SCORE   = 5,
    parameter int MAX_ROUNDS  = 9,
    parameter int SHOW_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                draw_en,
    input  logic                whose,
    input  logic [COLOR_W-1:0]  color1,
    input  logic [NUM_W-1:0]    number1,
    input  logic [COLOR_W-1:0]  color2,
    input  logic [NUM_W-1:0]    number2,
    input  logic                new_game,
    output logic [3:0]          score1,
    output logic [3:0]          score2,
    output logic [3:0]          round_no,
    output logic [1:0]          result,
    output logic                result_valid,
    output logic                turn_err,
    output logic                game_over,
    output logic [1:0]          champion
);

    localparam logic [3:0] WIN_S     = 4'(WIN_SCORE);
    localparam logic [3:0] MAX_R     = 4'(MAX_ROUNDS);
    localparam logic [3:0] SHOW_LAST = 4'(SHOW_CYCLES - 1);

    state_t     state;
    card_t      c1;
    card_t      c2;
    logic [3:0] show_cnt;
    logic       d_draw;
    logic       d_whose;
    result_t    round_res;
    logic       match_done;

    strobe_delay #(.DEPTH(VALUE_LAT)) u_strobe_delay (
        .clk     (clk),
        .rst     (rst),
        .draw_en (draw_en),
        .whose   (whose),
        .d_draw  (d_draw),
        .d_whose (d_whose)
    );

    always_comb begin
        round_res  = judge_cards(c1, c2);
        match_done = (score1 == WIN_S) || (score2 == WIN_S) || (round_no == MAX_R);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WAIT_P1;
            c1           <= '0;
            c2           <= '0;
            show_cnt     <= '0;
            score1       <= '0;
            score2       <= '0;
            round_no     <= '0;
            result       <= RES_NONE;
            result_valid <= 1'b0;
            turn_err     <= 1'b0;
            game_over    <= 1'b0;
            champion     <= RES_NONE;
        end else begin
            result_valid <= 1'b0;
            turn_err     <= 1'b0;
            case (state)
                WAIT_P1: if (d_draw) begin
                    if (!d_whose) begin
                        c1    <= '{number: number1, color: color1};
                        state <= WAIT_P2;
                    end else begin
                        turn_err <= 1'b1;
                    end
                end
                WAIT_P2: if (d_draw) begin
                    if (d_whose) begin
                        c2    <= '{number: number2, color: color2};
                        state <= JUDGE;
                    end else begin
                        turn_err <= 1'b1;
                    end
                end
                JUDGE: begin
                    result       <= round_res;
                    result_valid <= 1'b1;
                    if (round_res == RES_P1) score1 <= sat_inc(score1);
                    if (round_res == RES_P2) score2 <= sat_inc(score2);
                    round_no     <= sat_inc(round_no);
                    show_cnt     <= '0;
                    state        <= SHOW;
                end
                SHOW: begin
                    if (show_cnt == SHOW_LAST) begin
                        if (match_done) begin
                            state     <= OVER;
                            game_over <= 1'b1;
                            champion  <= (score1 > score2) ? RES_P1 :
                                         (score2 > score1) ? RES_P2 : RES_DRAW;
                        end else begin
                            state <= WAIT_P1;
                        end
                    end else begin
                        show_cnt <= show_cnt + 4'd1;
                    end
                end
                OVER: if (new_game) begin
                    score1    <= '0;
                    score2    <= '0;
                    round_no  <= '0;
                    result    <= RES_NONE;
                    champion  <= RES_NONE;
                    game_over <= 1'b0;
                    state     <= WAIT_P1;
                end
                default: state <= WAIT_P1;
            endcase
        end
    end

endmodule

// File: tb/tb_round_judge.sv
// tb/tb_round_judge.sv - directed scoreboard bench for round_judge
module tb_round_judge;

    localparam int VALUE_LAT = 3;

    logic       clk = 1'b0;
    logic       rst, draw_en, whose, new_game;
    logic [1:0] color1, color2;
    logic [2:0] number1, number2;
    logic [3:0] score1, score2, round_no;
    logic [1:0] result, champion;
    logic       result_valid, turn_err, game_over;

    typedef struct {
        logic [1:0] res;
        logic [3:0] s1;
        logic [3:0] s2;
        logic [3:0] rn;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         terr_cnt = 0;
    int         lat;
    logic [3:0] m_s1, m_s2, m_rn;

    always #5 clk = ~clk;

    round_judge #(
        .VALUE_LAT(VALUE_LAT), .WIN_SCORE(5), .MAX_ROUNDS(9), .SHOW_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .draw_en(draw_en), .whose(whose),
        .color1(color1), .number1(number1), .color2(color2), .number2(number2),
        .new_game(new_game), .score1(score1), .score2(score2), .round_no(round_no),
        .result(result), .result_valid(result_valid), .turn_err(turn_err),
        .game_over(game_over), .champion(champion)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_res(input logic [2:0] n1, input logic [1:0] c1,
                                           input logic [2:0] n2, input logic [1:0] c2);
        if (n1 > n2) return 2'b01;
        if (n1 < n2) return 2'b10;
        if (c1 > c2) return 2'b01;
        if (c1 < c2) return 2'b10;
        return 2'b11;
    endfunction

    always @(negedge clk) begin
        if (turn_err === 1'b1) terr_cnt++;
        if (result_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_result_valid", 8'd1, 8'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result",   8'(result),   8'(e.res));
                check("score1",   8'(score1),   8'(e.s1));
                check("score2",   8'(score2),   8'(e.s2));
                check("round_no", 8'(round_no), 8'(e.rn));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic draw(input logic w, input logic [1:0] c, input logic [2:0] n);
        @(negedge clk);
        if (!w) begin color1 = c; number1 = n; end
        else    begin color2 = c; number2 = n; end
        whose   = w;
        draw_en = 1'b1;
        @(negedge clk);
        draw_en = 1'b0;
        whose   = 1'b0;
    endtask

    task automatic push_exp(input logic [1:0] res);
        if (res == 2'b01 && m_s1 != 4'hF) m_s1++;
        if (res == 2'b10 && m_s2 != 4'hF) m_s2++;
        if (m_rn != 4'hF) m_rn++;
        sb.push_back('{res, m_s1, m_s2, m_rn});
    endtask

    task automatic play_round(input logic [2:0] n1, input logic [1:0] c1,
                              input logic [2:0] n2, input logic [1:0] c2);
        push_exp(ref_res(n1, c1, n2, c2));
        draw(1'b0, c1, n1);
        draw(1'b1, c2, n2);
        idle(12);
        check("sb_drain", 8'(sb.size()), 8'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_score1"},   8'(score1),   8'd0);
        check({tag, "_score2"},   8'(score2),   8'd0);
        check({tag, "_round_no"}, 8'(round_no), 8'd0);
        check({tag, "_result"},   8'(result),   8'd0);
        check({tag, "_champion"}, 8'(champion), 8'd0);
        check({tag, "_game_over"}, 8'(game_over), 8'd0);
        check({tag, "_rv"},       8'(result_valid), 8'd0);
        check({tag, "_terr"},     8'(turn_err), 8'd0);
    endtask

    initial begin
        rst = 1'b1; draw_en = 1'b0; whose = 1'b0; new_game = 1'b0;
        color1 = '0; color2 = '0; number1 = '0; number2 = '0;
        m_s1 = '0; m_s2 = '0; m_rn = '0;
        idle(3);
        check_zero("reset");
        rst = 1'b0;
        idle(2);

        // First round with latency measurement from the P2 strobe
        push_exp(ref_res(3'd5, 2'd1, 3'd3, 2'd2));
        draw(1'b0, 2'd1, 3'd5);
        draw(1'b1, 2'd2, 3'd3);
        lat = 1;
        while (result_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 8'(lat), 8'(VALUE_LAT + 2));
        idle(12);
        check("sb_drain", 8'(sb.size()), 8'd0);

        play_round(3'd4, 2'd2, 3'd4, 2'd3);
        play_round(3'd6, 2'd1, 3'd6, 2'd1);

        // Out-of-order strobes
        draw(1'b1, 2'd0, 3'd1);
        idle(6);
        check("terr_wait_p1", 8'(terr_cnt), 8'd1);
        push_exp(ref_res(3'd2, 2'd0, 3'd2, 2'd1));
        draw(1'b0, 2'd0, 3'd2);
        idle(4);
        draw(1'b0, 2'd3, 3'd7);
        idle(6);
        check("terr_wait_p2", 8'(terr_cnt), 8'd2);
        draw(1'b1, 2'd1, 3'd2);
        idle(12);
        check("sb_drain_c1_kept", 8'(sb.size()), 8'd0);
        check("not_over", 8'(game_over), 8'd0);

        // Reset while waiting for P2 with its strobe still in the delay line
        draw(1'b0, 2'd2, 3'd6);
        idle(4);
        draw(1'b1, 2'd0, 3'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("midreset");
        m_s1 = '0; m_s2 = '0; m_rn = '0;
        idle(15);
        check("midreset_quiet_rn", 8'(round_no), 8'd0);

        // Player 1 wins five straight
        play_round(3'd5, 2'd1, 3'd3, 2'd2);
        play_round(3'd7, 2'd0, 3'd6, 2'd3);
        play_round(3'd3, 2'd2, 3'd3, 2'd1);
        play_round(3'd4, 2'd3, 3'd0, 2'd0);
        play_round(3'd1, 2'd1, 3'd0, 2'd3);
        check("over5_game_over", 8'(game_over), 8'd1);
        check("over5_champion",  8'(champion),  8'd1);
        draw(1'b0, 2'd0, 3'd0);
        draw(1'b1, 2'd3, 3'd7);
        idle(12);
        check("over_ignore_score2", 8'(score2), 8'd0);
        check("over_ignore_rn",     8'(round_no), 8'd5);
        check("over_ignore_terr",   8'(terr_cnt), 8'd2);
        check("over_still",         8'(game_over), 8'd1);
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        check_zero("new_game");
        m_s1 = '0; m_s2 = '0; m_rn = '0;

        // Nine rounds ending 4-4 with one drawn round
        for (int i = 0; i < 4; i++) begin
            play_round(3'd6, 2'(i), 3'd2, 2'd0);
            play_round(3'd1, 2'd0, 3'd1, 2'd3);
        end
        check("nine_not_over_yet", 8'(game_over), 8'd0);
        play_round(3'd3, 2'd2, 3'd3, 2'd2);
        check("nine_game_over", 8'(game_over), 8'd1);
        check("nine_champion",  8'(champion),  8'd3);
        check("nine_round_no",  8'(round_no),  8'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
